// File: rtl/tick_divider.sv
// Programmable tick generator: emits a one-clock tick every div_reg clocks, periodic or one-shot,
// with divisor reloads deferred to period boundaries so a shorter divisor can never skip a tick.
module tick_divider #(
  parameter int WIDTH       = 26,
  parameter int DIV_DEFAULT = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic             sq,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DIV_DEFAULT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] pend_div;
  logic             pend_valid;
  logic             load_ok;
  logic             load_zero;
  logic             terminal;

  assign load_ok   = div_load && (div_in != '0);
  assign load_zero = div_load && (div_in == '0);
  // div_reg is never zero, so div_reg-1 cannot underflow.
  assign terminal  = (state == RUN) && en && (count == div_reg - WIDTH'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en && (!mode || start)) state_next = RUN;
      RUN:  if (!en || (terminal && mode)) state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      tick       <= 1'b0;
      sq         <= 1'b0;
      div_err    <= 1'b0;
      pend_valid <= 1'b0;
      div_reg    <= DIV_RESET;
    end else begin
      tick    <= terminal;
      div_err <= load_zero;

      if (state == RUN && en && !terminal) count <= count + WIDTH'(1);
      else                                 count <= '0;

      if (state_next == IDLE || mode) sq <= 1'b0;
      else if (terminal)              sq <= ~sq;

      // A load in RUN waits for the period boundary (terminal or abort); a same-edge load wins.
      if (state == IDLE) begin
        if (load_ok) div_reg <= div_in;
      end else if (terminal || !en) begin
        div_reg    <= load_ok ? div_in : (pend_valid ? pend_div : div_reg);
        pend_valid <= 1'b0;
      end else if (load_ok) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // NOTE: pend_div is left unreset; it is only ever read while pend_valid is set.
  always_ff @(posedge clk) begin
    if (state == RUN && en && !terminal && load_ok) pend_div <= div_in;
  end

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 26, giving the width of the counter and divisor.
REQ-002 The block SHALL have parameter DIV_DEFAULT, default 50_000_000, giving the reset divisor; the legal range is 1 to 2^WIDTH-1.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input en, 1 bit: run enable.
REQ-006 The block SHALL have input mode, 1 bit: 0 = periodic, 1 = one-shot.
REQ-007 The block SHALL have input start, 1 bit: one-shot trigger.
REQ-008 The block SHALL have input div_load, 1 bit: single-cycle request to load div_in.
REQ-009 The block SHALL have input div_in, WIDTH bits: requested divisor.
REQ-010 The block SHALL have output tick, 1 bit, registered: one-clk-wide pulse at each terminal count.
REQ-011 The block SHALL have output sq, 1 bit, registered: square wave with period 2*divisor in periodic mode.
REQ-012 The block SHALL have output busy, 1 bit: high while state == RUN.
REQ-013 The block SHALL have output count, WIDTH bits: current counter value.
REQ-014 The block SHALL have output div_err, 1 bit, registered: one-cycle pulse when a zero divisor load is rejected.

Function
REQ-015 The block SHALL implement two states, IDLE and RUN, plus registers div_reg, pend_div and pend_valid.
REQ-016 In IDLE, the block SHALL hold count at 0 and tick at 0.
REQ-017 IDLE SHALL go to RUN on an edge where en=1 and either (mode=0) or (mode=1 and start=1); count SHALL be loaded with 0 on that edge.
REQ-018 In RUN with en=1 and count != div_reg-1, the block SHALL increment count by 1 and drive tick to 0.
REQ-019 In RUN with en=1 and count == div_reg-1 (terminal count), the block SHALL load count with 0 and drive tick to 1 for exactly one cycle.
REQ-020 First-tick latency SHALL be exactly div_reg edges after the start edge; subsequent periodic ticks SHALL come every div_reg edges (div_reg=1 gives tick=1 on every cycle).
REQ-021 At terminal count, mode SHALL be sampled: mode=0 stays in RUN; mode=1 goes to IDLE, so a one-shot produces exactly one tick.
REQ-022 In RUN with en=0, the block SHALL go to IDLE, load count with 0 and drive tick to 0 on that edge, abandoning the partial period with no tick.
REQ-023 start SHALL be ignored while in RUN; a one-shot cannot be retriggered mid-period.
REQ-024 sq SHALL toggle on each edge that asserts tick while mode=0; it SHALL be 0 in one-shot mode and SHALL be cleared to 0 on every entry to IDLE.
REQ-025 div_load with div_in=0 SHALL be rejected: div_err=1 for the next cycle, and div_reg and the pending divisor unchanged.
REQ-026 div_load with div_in>=1 in IDLE SHALL load div_reg with div_in on that edge.
REQ-027 div_load with div_in>=1 in RUN SHALL store div_in in pend_div and set pend_valid; div_reg SHALL be unchanged until the next terminal-count edge.
REQ-028 At a terminal-count edge, the divisor for the new period SHALL be chosen in this priority: a valid div_load on that same edge, else pend_div if pend_valid, else div_reg; pend_valid SHALL be cleared on that edge.
REQ-029 Multiple loads within one period SHALL leave only the last valid value effective.
REQ-030 If RUN exits via en=0 with pend_valid set, pend_div SHALL be committed to div_reg on that edge.
REQ-031 The count comparison SHALL be unsigned at WIDTH bits; count SHALL never exceed div_reg-1 and never wrap past 2^WIDTH-1.
REQ-032 A div_load that lowers the divisor SHALL never cause a missed terminal count, because it takes effect only at period boundaries.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL force: state=IDLE, count=0, tick=0, sq=0, div_err=0, busy=0, pend_valid=0, div_reg=DIV_DEFAULT.
REQ-034 reset SHALL have priority over all other inputs, including a mid-period RUN and a coincident div_load (the load is lost).
REQ-035 The first tick after reset deassertion SHALL follow the REQ-017 to REQ-020 timing.

Verification
REQ-036 Periodic: WIDTH=8, div_reg=4, mode=0, en=1 held -> tick high on edges 4, 8, 12 after the start edge; sq toggles 0->1->0; count sequence 0,1,2,3,0.
REQ-037 One-shot: div_reg=5, mode=1, en=1, start pulse -> busy high for 5 cycles, a single tick on edge 5, then IDLE; a start pulse at edge 2 has no effect.
REQ-038 Reload: running with div=4, load 2 at count=1 -> that period completes at 4 cycles, following ticks every 2; load 0 -> div_err pulse, period unchanged.
REQ-039 Abort: en dropped at count=2 (div=4) -> no tick, count=0, sq=0, busy=0 on the next cycle.
REQ-040 Corners: div=1 gives tick high on every cycle in RUN; reset asserted mid-period gives all outputs at reset values and div_reg=DIV_DEFAULT; DIV_DEFAULT=50_000_000 with WIDTH=26 gives a tick every 50,000,000 cycles.
